// File: rtl/sequence_player.sv
// Plays a stored symbol sequence on one-hot LEDs, paced by the millisecond timer's tick.
// Optional feature macro SEQ_PLAYER_ABORT_EN adds an `abort` input that returns to IDLE.
module sequence_player #(
  parameter int unsigned ON_MS   = 500,
  parameter int unsigned OFF_MS  = 250,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(MAX_LEN):0]   seq_len,
  input  logic                       ms_tick,
`ifdef SEQ_PLAYER_ABORT_EN
  input  logic                       abort,
`endif
  output logic                       timer_en,
  output logic [$clog2(MAX_LEN)-1:0] rd_addr,
  input  logic [1:0]                 rd_data,
  output logic [3:0]                 led,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned   AW       = $clog2(MAX_LEN);
  localparam int unsigned   LW       = AW + 1;
  localparam logic [15:0]   ON_LAST  = 16'(ON_MS - 1);
  localparam logic [15:0]   OFF_LAST = 16'(OFF_MS - 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_SHOW,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] rd_addr_d;
  logic [LW-1:0] len_q, len_d;
  logic [3:0]    led_d;
  logic          busy_d, done_d, timer_en_d;

  // NOTE: every variable gets a default before the case statement so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    len_d     = len_q;
    rd_addr_d = rd_addr;
    led_d     = led;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d     = (seq_len > LEN_MAX) ? LEN_MAX : seq_len;
          idx_d     = '0;
          rd_addr_d = '0;
          cnt_d     = '0;
          state_d   = (seq_len == '0) ? S_DONE : S_ADDR;
        end
      end
      S_ADDR: state_d = S_DATA;
      S_DATA: begin
        led_d   = 4'b0001 << rd_data;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (ms_tick) begin
          if (cnt_q == ON_LAST) begin
            cnt_d   = '0;
            led_d   = '0;
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_GAP: begin
        if (ms_tick) begin
          if (cnt_q == OFF_LAST) begin
            cnt_d = '0;
            if ({1'b0, idx_q} == (len_q - 1'b1)) begin
              state_d = S_DONE;
            end else begin
              idx_d     = idx_q + 1'b1;
              rd_addr_d = idx_q + 1'b1;
              state_d   = S_ADDR;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef SEQ_PLAYER_ABORT_EN
    // Abort overrides whatever the case above decided, but only once playing.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      led_d   = '0;
    end
`endif

    // Status outputs are registered from the next state so they line up with it.
    busy_d     = (state_d != S_IDLE);
    timer_en_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      rd_addr  <= '0;
      led      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timer_en <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      rd_addr  <= rd_addr_d;
      led      <= led_d;
      busy     <= busy_d;
      done     <= done_d;
      timer_en <= timer_en_d;
    end
  end

endmodule
